rob_multi: RTL and testbench

- Parametrised successor to the single-commit reorder buffer.
- Circular buffer of DEPTH entries. Allocates one instruction per cycle from the decoder.
- Accepts WB_PORTS independent writebacks per cycle, with same-cycle operand bypass.
- Retires up to COMMIT_W oldest completed entries per cycle, in order, to the regfile.
- On a mispredicted branch at commit, flushes the buffer and issues a one-cycle redirect to ifetch.

---
 rtl/rob_multi_if.sv | 60 ++++++
 rtl/rob_multi.sv | 236 +++++++++++++++++++++++
 tb/tb_rob_multi.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_multi_if.sv
// Bus interface of the multi-commit reorder buffer.
// Groups the decoder allocation handshake, the writeback ports, the operand
// lookups and the retire/redirect outputs. The pipeline side uses the
// master modport, the reorder buffer uses the slave modport.
//   alloc_*   : decoder allocation request and the buffer's ready/next id
//   wb_*      : WB_PORTS packed writeback lanes (id, value, mispredict, target)
//   query_*   : two combinational operand lookups with same-cycle bypass
//   commit_*  : COMMIT_W registered retire slots, slot 0 oldest
//   flush*    : one-cycle redirect pulse and its pc
//   count     : occupied entries
//   halt      : sticky once a halt entry has retired
interface rob_multi_if #(
  parameter int IDX_W    = 4,
  parameter int WB_PORTS = 3,
  parameter int COMMIT_W = 2,
  parameter int REG_W    = 5
);
  logic                       alloc_valid;
  logic [1:0]                 alloc_kind;
  logic [REG_W-1:0]           alloc_rd;
  logic                       alloc_ready;
  logic [IDX_W-1:0]           alloc_id;

  logic [WB_PORTS-1:0]        wb_valid;
  logic [WB_PORTS*IDX_W-1:0]  wb_id;
  logic [WB_PORTS*32-1:0]     wb_value;
  logic [WB_PORTS-1:0]        wb_mispredict;
  logic [WB_PORTS*32-1:0]     wb_target;

  logic [2*IDX_W-1:0]         query_id;
  logic [1:0]                 query_ready;
  logic [63:0]                query_value;

  logic [COMMIT_W-1:0]        commit_valid;
  logic [COMMIT_W*REG_W-1:0]  commit_rd;
  logic [COMMIT_W*IDX_W-1:0]  commit_id;
  logic [COMMIT_W*32-1:0]     commit_value;
  logic                       flush;
  logic [31:0]                flush_pc;
  logic [IDX_W:0]             count;
  logic                       halt;

  modport master (
    output alloc_valid, alloc_kind, alloc_rd,
    output wb_valid, wb_id, wb_value, wb_mispredict, wb_target,
    output query_id,
    input  alloc_ready, alloc_id, query_ready, query_value,
    input  commit_valid, commit_rd, commit_id, commit_value,
    input  flush, flush_pc, count, halt
  );

  modport slave (
    input  alloc_valid, alloc_kind, alloc_rd,
    input  wb_valid, wb_id, wb_value, wb_mispredict, wb_target,
    input  query_id,
    output alloc_ready, alloc_id, query_ready, query_value,
    output commit_valid, commit_rd, commit_id, commit_value,
    output flush, flush_pc, count, halt
  );
endinterface

// File: rtl/rob_multi.sv
// Multi-commit reorder buffer.
// Circular buffer of DEPTH entries: one allocation per cycle, WB_PORTS
// writebacks per cycle with same-cycle operand bypass, up to COMMIT_W
// in-order retirements per cycle, and a flush/redirect when a mispredicted
// entry retires.
// Ports:
//   clk_in : clock, rising edge
//   rst_in : asynchronous active-high reset
//   rdy_in : global enable, low freezes all state and silences strobes
//   bus    : rob_multi_if slave modport (allocation, writeback, query,
//            commit, flush, count, halt)
module rob_multi #(
  parameter int DEPTH    = 16,
  parameter int IDX_W    = 4,
  parameter int WB_PORTS = 3,
  parameter int COMMIT_W = 2,
  parameter int REG_W    = 5
) (
  input logic        clk_in,
  input logic        rst_in,
  input logic        rdy_in,
  rob_multi_if.slave bus
);

  localparam logic [1:0]     KIND_HALT = 2'd3;
  localparam logic [IDX_W:0] DEPTH_C   = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] CNT_ONE   = {{IDX_W{1'b0}}, 1'b1};

  // entry storage
  logic              busy_r   [DEPTH];
  logic              done_r   [DEPTH];
  logic [1:0]        kind_r   [DEPTH];
  logic [REG_W-1:0]  rd_r     [DEPTH];
  logic [31:0]       value_r  [DEPTH];
  logic              misp_r   [DEPTH];
  logic [31:0]       target_r [DEPTH];

  logic [IDX_W-1:0]  head_r;
  logic [IDX_W-1:0]  tail_r;
  logic [IDX_W:0]    count_r;
  logic              halt_r;

  logic [COMMIT_W-1:0]       commit_valid_r;
  logic [COMMIT_W*REG_W-1:0] commit_rd_r;
  logic [COMMIT_W*IDX_W-1:0] commit_id_r;
  logic [COMMIT_W*32-1:0]    commit_value_r;
  logic                      flush_r;
  logic [31:0]               flush_pc_r;

  // unpacked writeback lanes
  logic [IDX_W-1:0]  wb_id_s     [WB_PORTS];
  logic [31:0]       wb_value_s  [WB_PORTS];
  logic [31:0]       wb_target_s [WB_PORTS];

  // commit decision
  logic [IDX_W-1:0]    slot_idx_s [COMMIT_W];
  logic [COMMIT_W-1:0] retire_s;
  logic [IDX_W:0]      retire_cnt_s;
  logic                chain_s;
  logic                flush_take_s;
  logic [31:0]         flush_tgt_s;
  logic                halt_take_s;

  logic                alloc_ready_s;
  logic                alloc_fire_s;
  logic [IDX_W:0]      alloc_inc_s;

  logic [IDX_W-1:0]    qid_s [2];
  logic [1:0]          query_ready_s;
  logic [63:0]         query_value_s;

  // Once halted nothing new may enter, so readiness also drops on halt.
  assign alloc_ready_s = (count_r < DEPTH_C) && !halt_r;
  assign alloc_fire_s  = rdy_in && bus.alloc_valid && alloc_ready_s;
  assign alloc_inc_s   = alloc_fire_s ? CNT_ONE : '0;

  // Split the packed writeback buses into per-port lanes.
  always_comb begin
    for (int p = 0; p < WB_PORTS; p++) begin
      wb_id_s[p]     = bus.wb_id[p*IDX_W +: IDX_W];
      wb_value_s[p]  = bus.wb_value[p*32 +: 32];
      wb_target_s[p] = bus.wb_target[p*32 +: 32];
    end
  end

  // Pick the in-order retire group from registered state only; a
  // mispredict or halt closes the group so younger slots stay put.
  always_comb begin
    retire_s     = '0;
    retire_cnt_s = '0;
    flush_take_s = 1'b0;
    flush_tgt_s  = 32'd0;
    halt_take_s  = 1'b0;
    chain_s      = rdy_in && !halt_r;
    for (int k = 0; k < COMMIT_W; k++) begin
      slot_idx_s[k] = head_r + IDX_W'(k);
      if (chain_s && busy_r[slot_idx_s[k]] && done_r[slot_idx_s[k]]) begin
        retire_s[k]  = 1'b1;
        retire_cnt_s = retire_cnt_s + CNT_ONE;
        if (misp_r[slot_idx_s[k]]) begin
          flush_take_s = 1'b1;
          flush_tgt_s  = target_r[slot_idx_s[k]];
          chain_s      = 1'b0;
        end else if (kind_r[slot_idx_s[k]] == KIND_HALT) begin
          halt_take_s = 1'b1;
          chain_s     = 1'b0;
        end else begin
          chain_s = 1'b1;
        end
      end else begin
        chain_s = 1'b0;
      end
    end
  end

  // Operand lookup: a same-cycle writeback beats stored state, higher port last.
  always_comb begin
    query_ready_s = 2'b00;
    query_value_s = 64'd0;
    for (int q = 0; q < 2; q++) begin
      qid_s[q] = bus.query_id[q*IDX_W +: IDX_W];
      if (done_r[qid_s[q]]) begin
        query_ready_s[q]          = 1'b1;
        query_value_s[q*32 +: 32] = value_r[qid_s[q]];
      end else begin
        query_ready_s[q]          = 1'b0;
        query_value_s[q*32 +: 32] = 32'd0;
      end
      for (int p = 0; p < WB_PORTS; p++) begin
        if (bus.wb_valid[p] && (wb_id_s[p] == qid_s[q])) begin
          query_ready_s[q]          = 1'b1;
          query_value_s[q*32 +: 32] = wb_value_s[p];
        end else begin
          query_ready_s[q]          = query_ready_s[q];
        end
      end
    end
  end

  // Entry array, pointers and occupancy.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        busy_r[i]   <= 1'b0;
        done_r[i]   <= 1'b0;
        kind_r[i]   <= 2'd0;
        rd_r[i]     <= '0;
        value_r[i]  <= 32'd0;
        misp_r[i]   <= 1'b0;
        target_r[i] <= 32'd0;
      end
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (rdy_in) begin
      if (flush_take_s) begin
        // redirect: everything in flight, including this cycle's traffic, dies
        for (int i = 0; i < DEPTH; i++) begin
          busy_r[i] <= 1'b0;
          done_r[i] <= 1'b0;
        end
        head_r  <= '0;
        tail_r  <= '0;
        count_r <= '0;
      end else begin
        // later ports overwrite earlier ones on the same id
        for (int p = 0; p < WB_PORTS; p++) begin
          if (bus.wb_valid[p] && busy_r[wb_id_s[p]] && !done_r[wb_id_s[p]]) begin
            done_r[wb_id_s[p]]   <= 1'b1;
            value_r[wb_id_s[p]]  <= wb_value_s[p];
            misp_r[wb_id_s[p]]   <= bus.wb_mispredict[p];
            target_r[wb_id_s[p]] <= wb_target_s[p];
          end
        end
        for (int k = 0; k < COMMIT_W; k++) begin
          if (retire_s[k]) begin
            busy_r[slot_idx_s[k]] <= 1'b0;
            done_r[slot_idx_s[k]] <= 1'b0;
          end
        end
        // the tail slot can never be retiring here: that would need a full buffer
        if (alloc_fire_s) begin
          busy_r[tail_r] <= 1'b1;
          done_r[tail_r] <= 1'b0;
          kind_r[tail_r] <= bus.alloc_kind;
          rd_r[tail_r]   <= bus.alloc_rd;
          misp_r[tail_r] <= 1'b0;
          tail_r         <= tail_r + {{(IDX_W-1){1'b0}}, 1'b1};
        end
        head_r  <= head_r + retire_cnt_s[IDX_W-1:0];
        count_r <= count_r + alloc_inc_s - retire_cnt_s;
      end
    end
  end

  // Registered retire, redirect and halt outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      commit_valid_r <= '0;
      commit_rd_r    <= '0;
      commit_id_r    <= '0;
      commit_value_r <= '0;
      flush_r        <= 1'b0;
      flush_pc_r     <= 32'd0;
      halt_r         <= 1'b0;
    end else if (!rdy_in) begin
      // paused: strobes drop so nothing is seen twice, data holds
      commit_valid_r <= '0;
      flush_r        <= 1'b0;
    end else begin
      commit_valid_r <= retire_s;
      for (int k = 0; k < COMMIT_W; k++) begin
        commit_rd_r[k*REG_W +: REG_W] <= retire_s[k] ? rd_r[slot_idx_s[k]] : '0;
        commit_id_r[k*IDX_W +: IDX_W] <= retire_s[k] ? slot_idx_s[k] : '0;
        commit_value_r[k*32 +: 32]    <= retire_s[k] ? value_r[slot_idx_s[k]] : 32'd0;
      end
      flush_r    <= flush_take_s;
      flush_pc_r <= flush_take_s ? flush_tgt_s : 32'd0;
      halt_r     <= halt_r | halt_take_s;
    end
  end

  assign bus.alloc_ready  = alloc_ready_s;
  assign bus.alloc_id     = tail_r;
  assign bus.query_ready  = query_ready_s;
  assign bus.query_value  = query_value_s;
  assign bus.commit_valid = commit_valid_r;
  assign bus.commit_rd    = commit_rd_r;
  assign bus.commit_id    = commit_id_r;
  assign bus.commit_value = commit_value_r;
  assign bus.flush        = flush_r;
  assign bus.flush_pc     = flush_pc_r;
  assign bus.count        = count_r;
  assign bus.halt         = halt_r;

endmodule

// File: tb/tb_rob_multi.sv
// Directed bench for rob_multi: fill/drain, out-of-order completion,
// mispredict flush, same-id writeback priority with bypass, pause and halt.
module tb_rob_multi;
  localparam int IDX_W    = 4;
  localparam int WB_PORTS = 3;
  localparam int COMMIT_W = 2;
  localparam int REG_W    = 5;

  logic clk_in = 1'b0;
  logic rst_in;
  logic rdy_in;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_id;
  int busy_cycles;

  rob_multi_if #(.IDX_W(IDX_W), .WB_PORTS(WB_PORTS), .COMMIT_W(COMMIT_W), .REG_W(REG_W)) bus_if ();

  rob_multi #(.DEPTH(16), .IDX_W(IDX_W), .WB_PORTS(WB_PORTS), .COMMIT_W(COMMIT_W), .REG_W(REG_W)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .bus    (bus_if)
  );

  // free-running clock
  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic idle();
    bus_if.alloc_valid   = 1'b0;
    bus_if.alloc_kind    = 2'd0;
    bus_if.alloc_rd      = '0;
    bus_if.wb_valid      = '0;
    bus_if.wb_id         = '0;
    bus_if.wb_value      = '0;
    bus_if.wb_mispredict = '0;
    bus_if.wb_target     = '0;
  endtask

  task automatic set_wb(input int p, input int id, input int val, input int misp, input int tgt);
    bus_if.wb_valid[p]           = 1'b1;
    bus_if.wb_id[p*IDX_W +: IDX_W] = 4'(id);
    bus_if.wb_value[p*32 +: 32]  = 32'(val);
    bus_if.wb_mispredict[p]      = (misp != 0);
    bus_if.wb_target[p*32 +: 32] = 32'(tgt);
  endtask

  task automatic alloc(input int kind, input int rd);
    idle();
    bus_if.alloc_valid = 1'b1;
    bus_if.alloc_kind  = 2'(kind);
    bus_if.alloc_rd    = 5'(rd);
    tick();
    idle();
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1;
    rdy_in = 1'b1;
    bus_if.query_id = 8'h00;
    idle();
    #1;
    check_eq("rst_count", 64'(bus_if.count), 64'd0);
    check_eq("rst_alloc_ready", 64'(bus_if.alloc_ready), 64'd1);
    check_eq("rst_alloc_id", 64'(bus_if.alloc_id), 64'd0);
    check_eq("rst_commit_valid", 64'(bus_if.commit_valid), 64'd0);
    check_eq("rst_flush", 64'(bus_if.flush), 64'd0);
    check_eq("rst_halt", 64'(bus_if.halt), 64'd0);
    tick();
    rst_in = 1'b0;

    // fill the buffer, then drain at two per cycle
    for (int i = 0; i < 16; i++) alloc(0, i + 1);
    check_eq("t1_full_ready", 64'(bus_if.alloc_ready), 64'd0);
    check_eq("t1_full_count", 64'(bus_if.count), 64'd16);
    check_eq("t1_full_alloc_id", 64'(bus_if.alloc_id), 64'd0);
    exp_id = 0;
    busy_cycles = 0;
    for (int c = 0; c < 20; c++) begin
      idle();
      if (c < 6) begin
        for (int p = 0; p < 3; p++) begin
          int id;
          id = c * 3 + p;
          if (id < 16) set_wb(p, id, 32'h100 + id, 0, 0);
        end
      end
      tick();
      if (bus_if.commit_valid != 2'b00) busy_cycles++;
      for (int k = 0; k < 2; k++) begin
        if (bus_if.commit_valid[k]) begin
          check_eq("t1_id", 64'(bus_if.commit_id[k*IDX_W +: IDX_W]), 64'(exp_id));
          check_eq("t1_value", 64'(bus_if.commit_value[k*32 +: 32]), 64'(32'h100 + exp_id));
          check_eq("t1_rd", 64'(bus_if.commit_rd[k*REG_W +: REG_W]), 64'(exp_id + 1));
          exp_id++;
        end
      end
    end
    check_eq("t1_total", 64'(exp_id), 64'd16);
    check_eq("t1_cycles", 64'(busy_cycles), 64'd8);
    check_eq("t1_count_end", 64'(bus_if.count), 64'd0);

    // out-of-order completion, in-order retirement
    check_eq("t2_alloc_id", 64'(bus_if.alloc_id), 64'd0);
    for (int i = 0; i < 3; i++) alloc(0, 7);
    set_wb(0, 2, 32'h33, 0, 0);
    tick();
    check_eq("t2_wait0", 64'(bus_if.commit_valid), 64'd0);
    idle();
    tick();
    check_eq("t2_wait1", 64'(bus_if.commit_valid), 64'd0);
    set_wb(1, 0, 32'h11, 0, 0);
    tick();
    check_eq("t2_wait2", 64'(bus_if.commit_valid), 64'd0);
    idle();
    set_wb(0, 1, 32'h22, 0, 0);
    tick();
    check_eq("t2_first_valid", 64'(bus_if.commit_valid), 64'd1);
    check_eq("t2_first_id", 64'(bus_if.commit_id[3:0]), 64'd0);
    check_eq("t2_first_value", 64'(bus_if.commit_value[31:0]), 64'h11);
    idle();
    tick();
    check_eq("t2_pair_valid", 64'(bus_if.commit_valid), 64'd3);
    check_eq("t2_pair_ids", 64'(bus_if.commit_id), 64'h21);
    check_eq("t2_pair_values", 64'(bus_if.commit_value), 64'h0000_0033_0000_0022);
    check_eq("t2_count", 64'(bus_if.count), 64'd0);

    // mispredicted branch at head flushes
    do_reset();
    alloc(1, 1);
    alloc(0, 2);
    alloc(0, 3);
    alloc(0, 4);
    set_wb(0, 0, 32'h5, 1, 32'h1000);
    set_wb(1, 1, 32'h6, 0, 0);
    set_wb(2, 2, 32'h7, 0, 0);
    tick();
    idle();
    set_wb(0, 3, 32'h9, 0, 0);
    bus_if.alloc_valid = 1'b1;
    tick();
    check_eq("t3_commit_valid", 64'(bus_if.commit_valid), 64'd1);
    check_eq("t3_commit_id", 64'(bus_if.commit_id[3:0]), 64'd0);
    check_eq("t3_flush", 64'(bus_if.flush), 64'd1);
    check_eq("t3_flush_pc", 64'(bus_if.flush_pc), 64'h1000);
    check_eq("t3_count", 64'(bus_if.count), 64'd0);
    check_eq("t3_alloc_id", 64'(bus_if.alloc_id), 64'd0);
    idle();
    tick();
    check_eq("t3_flush_gone", 64'(bus_if.flush), 64'd0);
    check_eq("t3_no_commit", 64'(bus_if.commit_valid), 64'd0);
    check_eq("t3_count_after", 64'(bus_if.count), 64'd0);

    // two ports on one id: higher port wins, bypassed to query
    for (int i = 0; i < 6; i++) alloc(0, i);
    set_wb(0, 5, 32'hA, 0, 0);
    set_wb(2, 5, 32'hB, 0, 0);
    bus_if.query_id = 8'h45;
    #1;
    check_eq("t4_bypass_ready", 64'(bus_if.query_ready), 64'd1);
    check_eq("t4_bypass_value", bus_if.query_value, 64'hB);
    tick();
    idle();
    #1;
    check_eq("t4_stored_ready", 64'(bus_if.query_ready), 64'd1);
    check_eq("t4_stored_value", bus_if.query_value, 64'hB);
    check_eq("t4_no_commit", 64'(bus_if.commit_valid), 64'd0);

    // pause with retirable entries and live writebacks
    set_wb(0, 0, 32'h50, 0, 0);
    set_wb(1, 1, 32'h51, 0, 0);
    tick();
    idle();
    rdy_in = 1'b0;
    set_wb(0, 2, 32'h52, 0, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("t5_paused_commit", 64'(bus_if.commit_valid), 64'd0);
      check_eq("t5_paused_count", 64'(bus_if.count), 64'd6);
    end
    rdy_in = 1'b1;
    idle();
    bus_if.query_id = 8'h02;
    tick();
    check_eq("t5_resume_valid", 64'(bus_if.commit_valid), 64'd3);
    check_eq("t5_resume_ids", 64'(bus_if.commit_id), 64'h10);
    check_eq("t5_resume_values", 64'(bus_if.commit_value), 64'h0000_0051_0000_0050);
    check_eq("t5_wb_ignored", 64'(bus_if.query_ready[0]), 64'd0);
    tick();
    check_eq("t5_id2_not_done", 64'(bus_if.commit_valid), 64'd0);

    // halt at id2, id3 behind it must never retire
    do_reset();
    alloc(0, 1);
    alloc(0, 2);
    alloc(3, 0);
    alloc(0, 4);
    set_wb(0, 0, 32'h70, 0, 0);
    set_wb(1, 1, 32'h71, 0, 0);
    set_wb(2, 2, 32'h72, 0, 0);
    tick();
    idle();
    set_wb(0, 3, 32'h73, 0, 0);
    tick();
    check_eq("t6_pair", 64'(bus_if.commit_valid), 64'd3);
    idle();
    tick();
    check_eq("t6_halt_valid", 64'(bus_if.commit_valid), 64'd1);
    check_eq("t6_halt_id", 64'(bus_if.commit_id[3:0]), 64'd2);
    check_eq("t6_halt", 64'(bus_if.halt), 64'd1);
    check_eq("t6_count", 64'(bus_if.count), 64'd1);
    bus_if.alloc_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_eq("t6_no_commit", 64'(bus_if.commit_valid), 64'd0);
      check_eq("t6_halt_sticky", 64'(bus_if.halt), 64'd1);
      check_eq("t6_count_frozen", 64'(bus_if.count), 64'd1);
    end
    idle();
    #2;
    rst_in = 1'b1;
    #1;
    check_eq("t6_rst_halt", 64'(bus_if.halt), 64'd0);
    check_eq("t6_rst_count", 64'(bus_if.count), 64'd0);
    check_eq("t6_rst_commit", 64'(bus_if.commit_valid), 64'd0);
    check_eq("t6_rst_alloc_id", 64'(bus_if.alloc_id), 64'd0);
    check_eq("t6_rst_flush", 64'(bus_if.flush), 64'd0);
    tick();
    rst_in = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
